uart_cmd_sequencer: RTL and testbench

- Sits behind the 8x-oversampled RS-232 byte receiver; consumes its one-cycle byte strobes and end-of-packet pulse.
- Parses framed host commands, buffers the payload, verifies the checksum, then issues a burst of register/memory writes on a valid/ready write port.
- Payload is committed only after the checksum passes, so a corrupted frame never reaches the register space.

---
 rtl/uart_cmd_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// Framed command parser behind a byte receiver: buffers the payload, verifies the checksum, then
// replays WRITE payloads on a valid/ready port. Define UART_CMD_TIMEOUT_EN to abort frames on rx_endofpacket.
module uart_cmd_sequencer #(
    parameter int         ADDR_W    = 8,
    parameter int         MAX_LEN   = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_data_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_endofpacket,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [7:0]        drop_cnt,
    output logic              busy
);
    localparam int         IDX_W    = $clog2(MAX_LEN + 1);
    localparam int         BUF_AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_LEN, S_PAYLOAD, S_CHK, S_COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic              cmd_wr_q, cmd_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [IDX_W-1:0]  len_q, len_d, idx_q, idx_d, idx_inc;
    logic [7:0]        sum_q, sum_d, sum_nxt;
    logic [7:0]        wr_data_q, wr_data_d, drop_cnt_q, drop_cnt_d;
    logic              wr_en_q, wr_en_d, frame_done_q, frame_done_d, frame_err_q, frame_err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              buf_we;
    logic [7:0]        buf_q [2**BUF_AW];

    always_comb begin
        state_d      = state_q;
        cmd_wr_d     = cmd_wr_q;
        addr_d       = addr_q;
        len_d        = len_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        wr_en_d      = wr_en_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        drop_cnt_d   = drop_cnt_q;
        err_code_d   = err_code_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        buf_we       = 1'b0;
        sum_nxt      = sum_q + rx_data;
        idx_inc      = idx_q + IDX_W'(1);

        case (state_q)
            S_IDLE: begin
                if (rx_data_ready && rx_data == SYNC_BYTE) begin
                    state_d = S_CMD;
                    sum_d   = 8'd0;
                end
            end
            S_CMD: begin
                if (rx_data_ready) begin
                    if (rx_data[7:1] == 7'd0) begin
                        cmd_wr_d = rx_data[0];
                        sum_d    = sum_nxt;
                        state_d  = S_ADDR;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd0;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_ADDR: begin
                if (rx_data_ready) begin
                    addr_d  = ADDR_W'(rx_data);
                    sum_d   = sum_nxt;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_data_ready) begin
                    if (rx_data == 8'd0 || {1'b0, rx_data} > MAX_LEN9 ||
                        (!cmd_wr_q && rx_data != 8'd1)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = S_IDLE;
                    end else begin
                        len_d   = rx_data[IDX_W-1:0];
                        idx_d   = '0;
                        sum_d   = sum_nxt;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_data_ready) begin
                    buf_we = 1'b1;
                    sum_d  = sum_nxt;
                    idx_d  = idx_inc;
                    if (idx_inc == len_q) state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_data_ready) begin
                    if (sum_nxt != 8'd0) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = S_IDLE;
                    end else if (cmd_wr_q) begin
                        idx_d   = '0;
                        state_d = S_COMMIT;
                    end else begin
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
            end
            S_COMMIT: begin
                if (rx_data_ready && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                // First cycle in COMMIT only loads beat 0; afterwards each accept advances one beat.
                if (!wr_en_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q + ADDR_W'(idx_q);
                    wr_data_d = buf_q[idx_q[BUF_AW-1:0]];
                end else if (wr_ready) begin
                    if (idx_inc == len_q) begin
                        wr_en_d      = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        idx_d     = idx_inc;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                        wr_data_d = buf_q[idx_inc[BUF_AW-1:0]];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef UART_CMD_TIMEOUT_EN
        // Any byte in this cycle is handled first; only a frame still in flight is aborted.
        if (rx_endofpacket && state_q inside {S_CMD, S_ADDR, S_LEN, S_PAYLOAD, S_CHK} &&
            state_d inside {S_CMD, S_ADDR, S_LEN, S_PAYLOAD, S_CHK}) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
            state_d     = S_IDLE;
        end
`endif
    end

`ifndef UART_CMD_TIMEOUT_EN
    logic unused_eop;
    assign unused_eop = rx_endofpacket;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_wr_q     <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            sum_q        <= 8'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'd0;
            drop_cnt_q   <= 8'd0;
            err_code_q   <= 2'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_wr_q     <= cmd_wr_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            drop_cnt_q   <= drop_cnt_d;
            err_code_q   <= err_code_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[idx_q[BUF_AW-1:0]] <= rx_data;
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign err_code   = err_code_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Randomized scoreboard bench for uart_cmd_sequencer; expectations come from a frame-level model.
module tb_uart_cmd_sequencer;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       rx_data_ready = 1'b0, rx_endofpacket = 1'b0, wr_ready = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       wr_en, frame_done, frame_err, busy;
    logic [7:0] wr_addr, wr_data, drop_cnt;
    logic [1:0] err_code;

    uart_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
        .rx_endofpacket(rx_endofpacket), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .frame_done(frame_done), .frame_err(frame_err),
        .err_code(err_code), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0, cyc = 0, rdy_mode = 0, model_drop = 0;
    logic [15:0] exp_wr[$];
    int          exp_out[$];   // 0..3 = error code, 4 = frame_done
    int          acc_cyc[$];
    logic [7:0]  pl[16];
    bit          hold_pend = 1'b0;
    logic [15:0] hold_val;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // wr_ready: 0 random, 1 held low, 2 held high, 3 toggling
    always @(posedge clk) begin
        cyc++;
        #1;
        case (rdy_mode)
            0: wr_ready = 1'($urandom_range(0, 1));
            1: wr_ready = 1'b0;
            2: wr_ready = 1'b1;
            default: wr_ready = ~wr_ready;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_pend) check("beat_held", {wr_en, wr_addr, wr_data}, {1'b1, hold_val});
            hold_pend = 1'b0;
            if (wr_en) begin
                if (wr_ready) begin
                    acc_cyc.push_back(cyc);
                    if (exp_wr.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
                    end else check("write", {wr_addr, wr_data}, exp_wr.pop_front());
                end else begin
                    hold_pend = 1'b1;
                    hold_val  = {wr_addr, wr_data};
                end
            end
            if (frame_done || frame_err) begin
                check("done_err_exclusive", int'(frame_done && frame_err), 0);
                check("busy_after_frame", busy, 0);
                if (exp_out.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_outcome: got done=%0d err=%0d code=%0d expected none",
                             frame_done, frame_err, err_code);
                end else check("outcome", frame_done ? 4 : int'(err_code), exp_out.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data = b; rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic pulse_eop();
        @(posedge clk); #1; rx_endofpacket = 1'b1;
        @(posedge clk); #1; rx_endofpacket = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_out.size() != 0 && n < 3000) begin @(posedge clk); n++; end
        if (exp_out.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d outcomes pending expected 0", exp_out.size());
            exp_out.delete();
        end
        @(negedge clk);
        check("writes_left", exp_wr.size(), 0);
        exp_wr.delete();
    endtask

    // Frame-level reference: decide the outcome from the frame rules, send only what the DUT consumes.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] len,
                             input int chk_ovr, input int ninj);
        logic [7:0] sum, chk;
        int code;
        sum = cmd + addr + len;
        for (int i = 0; i < len && i < 16; i++) sum = sum + pl[i];
        chk = (chk_ovr >= 0) ? 8'(chk_ovr) : 8'h00 - sum;
        if (cmd > 8'd1) code = 0;
        else if (len == 0 || len > 16 || (cmd == 8'd0 && len != 8'd1)) code = 1;
        else if (8'(sum + chk) != 8'd0) code = 2;
        else code = 4;
        if (code == 4 && cmd == 8'd1)
            for (int i = 0; i < len; i++) exp_wr.push_back({8'(addr + i), pl[i]});
        if (ninj > 0) rdy_mode = 1;
        exp_out.push_back(code);
        send_byte(8'hAA);
        send_byte(cmd);
        if (code != 0) begin
            send_byte(addr);
            send_byte(len);
            if (code != 1) begin
                for (int i = 0; i < len; i++) send_byte(pl[i]);
                send_byte(chk);
            end
        end
        if (ninj > 0) begin
            repeat (ninj) send_byte(8'($urandom));
            model_drop = (model_drop + ninj > 255) ? 255 : model_drop + ninj;
            rdy_mode = 0;
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [7:0] cmd, len;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Basic write, back-to-back beats
        rdy_mode = 2;
        pl[0] = 8'h55; pl[1] = 8'h66;
        acc_cyc.delete();
        run_frame(8'h01, 8'h10, 8'h02, 8'h32, 0);
        check("b2b_beats", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) check("b2b_gap", acc_cyc[1] - acc_cyc[0], 1);

        run_frame(8'h01, 8'h10, 8'h02, 8'h33, 0);   // bad checksum
        run_frame(8'h05, 8'h00, 8'h00, -1, 0);      // bad CMD
        run_frame(8'h01, 8'h00, 8'h00, -1, 0);      // LEN 0
        run_frame(8'h01, 8'h00, 8'd17, -1, 0);      // LEN > MAX_LEN
        pl[0] = 8'h3C;
        run_frame(8'h00, 8'h20, 8'h01, -1, 0);      // NOP
        run_frame(8'h00, 8'h20, 8'h02, -1, 0);      // NOP with LEN 2

        // Address wrap with stalled sink
        rdy_mode = 3;
        pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
        run_frame(8'h01, 8'hFE, 8'h03, -1, 0);

        // Bytes during COMMIT are dropped, next frame unaffected
        rdy_mode = 0;
        run_frame(8'h01, 8'h40, 8'h03, -1, 3);
        check("drop_cnt_3", drop_cnt, model_drop);
        pl[0] = 8'h55; pl[1] = 8'h66;
        run_frame(8'h01, 8'h10, 8'h02, -1, 0);

        // rx_endofpacket mid-frame
        exp_out.push_back(0);
        exp_out.delete();
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h10);
`ifdef UART_CMD_TIMEOUT_EN
        exp_out.push_back(3);
        pulse_eop();
        drain();
`else
        pulse_eop();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("eop_ignored_busy", busy, 1);
        exp_out.push_back(1);
        send_byte(8'h00);
        drain();
`endif
        run_frame(8'h01, 8'h10, 8'h02, -1, 0);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 8'hA9)));
            r = $urandom_range(0, 99);
            cmd = (r < 70) ? 8'h01 : (r < 85) ? 8'h00 : 8'($urandom_range(2, 255));
            r = $urandom_range(0, 99);
            if (cmd == 8'h00) len = (r < 80) ? 8'd1 : 8'($urandom_range(0, 3));
            else len = (r < 85) ? 8'($urandom_range(1, 16)) : (r < 92) ? 8'd0 : 8'($urandom_range(17, 255));
            for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
            run_frame(cmd, 8'($urandom), len, ($urandom_range(0, 99) < 20) ? int'($urandom_range(0, 255)) : -1, 0);
        end

        // drop_cnt saturation
        for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
        run_frame(8'h01, 8'h80, 8'h02, -1, 260);
        check("drop_cnt_sat", drop_cnt, model_drop);
        check("drop_model_sat", model_drop, 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
